mdio_responder: RTL and testbench
=================================

# mdio_responder

Station-management target (PHY side) for the Ethernet MDIO bus. Decodes IEEE 802.3 clause-22 frames arriving on MDC/MDIO from a management master. Serves reads from, and applies writes to, a 32×16 register file. Used as a PHY-side model in system simulation and as the management port of FPGA-resident PHY/loopback logic. MDC and MDIO are asynchronous to `i_clk` and are oversampled.

## Interface
- `PHYADDR`, 5'h01, PHY address this block answers to. Address 0 is not a broadcast address.
- `PREAMBLE_LEN`, 32, consecutive 1 bits required before a start bit, range 0..32. 0 means preamble suppression.
- `PHYID1`, 16'h2000, read-only value of register 2.
- `PHYID2`, 16'h5C90, read-only value of register 3.
- `BMCR_RST`, 16'h3100, reset value of register 0.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset. Asynchronous and active-low; one clock domain.
- `i_mdc`  in  1  management clock from the master (asynchronous).
- `i_mdio`  in  1  MDIO pad input (asynchronous).
- `o_mdio`  out  1  MDIO drive value.
- `o_mdwe`  out  1  MDIO drive enable; 1 = drive `o_mdio`, 0 = tri-state.
- `i_status`  in  16  live value returned for register 1. Read-only.
- `o_wr_stb`  out  1  one-cycle pulse when a matching write frame completes.
- `o_wr_addr`  out  5  register address of the last write.
- `o_wr_data`  out  16  data of the last write, as received.
- `o_phy_rst`  out  1  one-cycle pulse when register 0 is written with bit 15 = 1.

## Operation
- **Synchronisers:** `i_mdc` and `i_mdio` each pass through 2 flops. A third MDC flop gives `rise` = synced MDC 0→1. All bit-level action happens only in cycles with `rise`, using the synced MDIO value.
- **Preamble counter:** 6 bits. Increments on each sampled 1 and saturates at `PREAMBLE_LEN`. Cleared on a sampled 0 and on every return to PRE.
- **State machine** (one step per `rise`):
  - PRE: a sampled 0 with count ≥ `PREAMBLE_LEN` → START. Otherwise stay in PRE.
  - START: sampled 1 → OP. Sampled 0 → PRE.
  - OP: 2 bits. 10 = read, 01 = write. 00 or 11 → PRE after the second bit.
  - ADDR: 10 bits, PHYAD then REGAD, MSB first. After the 10th bit, latch `match = (PHYAD == PHYADDR)`. On a read, also snapshot the register into a 16-bit shift register.
  - TA: 2 bits.
  - DATA: 16 bits, then → PRE with count 0.
- **Read path** (only when read and `match`):
  - TA rise 1: `o_mdwe` ← 1, `o_mdio` ← 0.
  - TA rise 2: `o_mdio` ← D15.
  - DATA rises 1..15: `o_mdio` ← D14..D0.
  - DATA rise 16: `o_mdwe` ← 0, `o_mdio` ← 1.
  - The master samples TA0 at TA rise 2 and D15..D0 at DATA rises 1..16.
- **Write path:**
  - TA bits are not checked.
  - DATA rises 1..16 shift in D15..D0.
  - If `match`, the cycle after DATA rise 16: `o_wr_stb` = 1 and `o_wr_addr`/`o_wr_data` update.
  - Register file update happens in the same cycle as `o_wr_stb`.
- **Mismatched PHYAD:** the frame is tracked to its end, with no drive, no write and no strobe.
- **Register map:**
  - Reg 0: reset value `BMCR_RST`. A write with bit 15 = 1 pulses `o_phy_rst` and stores the data with bit 15 cleared, so bit 15 self-clears.
  - Reg 1: returns `i_status`, sampled at the snapshot.
  - Regs 2 and 3: return `PHYID1` and `PHYID2`. Writes are ignored in storage, but `o_wr_stb` still pulses.
  - Regs 4–31: read/write, reset value 0.

## Timing
- Reset values: state PRE, count 0, `o_mdio` = 1, `o_mdwe` = 0, `o_wr_stb` = 0, `o_wr_addr` = 0, `o_wr_data` = 0, `o_phy_rst` = 0.
- `i_rst_n` low mid-frame releases `o_mdwe` immediately (asynchronously). The frame in progress is abandoned.
- Drive changes occur exactly 1 `i_clk` after the `rise` cycle, i.e. ≤ 4 `i_clk` after the MDC pin edge.
- MDC high time and low time must each be ≥ 4 `i_clk`. Slower MDC, or MDC stopped indefinitely, is legal.
- There is no preamble carry-over between frames. After DATA the count restarts at 0, so back-to-back frames each need `PREAMBLE_LEN` ones. With `PREAMBLE_LEN` = 0, a 0 immediately after DATA starts a new frame.
- `o_wr_stb` and `o_phy_rst` are high for exactly 1 cycle. `o_wr_addr` and `o_wr_data` hold until the next matching write.

## Test plan
- **Read ID:** 32 ones, then 01 10 00001 00010, released TA. Expect `o_mdwe` high from TA rise 1 through DATA rise 15, TA bit 0, data 0x2000 MSB first, then `o_mdwe` low after DATA rise 16.
- **Write/readback:** write reg 4 = 0xA5C3. Expect one `o_wr_stb` with `o_wr_addr` = 4 and `o_wr_data` = 0xA5C3. A subsequent read of reg 4 returns 0xA5C3.
- **Soft reset:** write reg 0 = 0x9200. Expect `o_phy_rst` pulse. A read of reg 0 returns 0x1200.
- **Address mismatch and bad opcode:**
  - PHYAD 5'h02 read: `o_mdwe` stays 0 for the whole frame.
  - Opcode 11: return to PRE; the following valid frame (fresh preamble) is answered.
- **Short preamble:** 31 ones then a read frame. No response, no strobe.
- **Reset mid-read:** pulse `i_rst_n` low during DATA bit 7. Expect `o_mdwe` = 0 at once, outputs at reset values, and the next full frame served normally.

Source files
------------

// File: rtl/mdio_responder.sv
// Clause-22 MDIO target: oversamples MDC/MDIO, decodes read/write frames
// addressed to PHYADDR and serves a 32x16 management register file.
module mdio_responder #(
  parameter logic [4:0]  PHYADDR      = 5'h01,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] PHYID1       = 16'h2000,
  parameter logic [15:0] PHYID2       = 16'h5C90,
  parameter logic [15:0] BMCR_RST     = 16'h3100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdwe,
  input  logic [15:0] i_status,
  output logic        o_wr_stb,
  output logic [4:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_phy_rst
);

  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

  typedef enum logic [2:0] {
    S_PRE,
    S_START,
    S_OP,
    S_ADDR,
    S_TA,
    S_DATA
  } state_t;

  state_t      state;
  logic [5:0]  pre_cnt;
  logic [3:0]  bit_cnt;
  logic        op_msb;
  logic        is_read;
  logic        match;
  logic [9:0]  addr_sr;
  logic [15:0] rd_sr;
  logic [15:0] wr_sr;
  logic [15:0] regs [32];

  logic        mdc_p0, mdc_p1, mdc_p2;
  logic        mdio_p0, mdio_p1;
  logic        rise;
  logic        bit_in;
  logic [4:0]  snap_ra;
  logic [15:0] rd_word;
  logic [15:0] wr_word;
  logic [4:0]  wr_ra;
  logic        drive;

  function automatic logic [5:0] pre_inc(input logic [5:0] c);
    return (c >= PRE_MAX) ? PRE_MAX : c + 6'd1;
  endfunction

  // Bit 15 of the control register is a self-clearing reset request.
  function automatic logic [15:0] bmcr_store(input logic [15:0] d);
    return {1'b0, d[14:0]};
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2 gives the MDC rising-edge detect.
  // Idle-high reset keeps a high MDC at reset release from faking a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mdc_p0  <= 1'b1;
      mdc_p1  <= 1'b1;
      mdc_p2  <= 1'b1;
      mdio_p0 <= 1'b1;
      mdio_p1 <= 1'b1;
    end else begin
      mdc_p0  <= i_mdc;
      mdc_p1  <= mdc_p0;
      mdc_p2  <= mdc_p1;
      mdio_p0 <= i_mdio;
      mdio_p1 <= mdio_p0;
    end
  end

  assign rise    = mdc_p1 & ~mdc_p2;
  assign bit_in  = mdio_p1;
  assign snap_ra = {addr_sr[3:0], bit_in};
  assign wr_word = {wr_sr[14:0], bit_in};
  assign wr_ra   = addr_sr[4:0];
  assign drive   = is_read & match;

  always_comb begin
    rd_word = regs[snap_ra];
    case (snap_ra)
      5'd1:    rd_word = i_status;
      5'd2:    rd_word = PHYID1;
      5'd3:    rd_word = PHYID2;
      default: rd_word = regs[snap_ra];
    endcase
  end

  // Frame shift registers carry data only and need no reset.
  always_ff @(posedge i_clk) begin
    if (rise) begin
      case (state)
        S_ADDR: begin
          addr_sr <= {addr_sr[8:0], bit_in};
          if (bit_cnt == 4'd9 && is_read) rd_sr <= rd_word;
        end
        S_TA: begin
          if (bit_cnt == 4'd1) rd_sr <= {rd_sr[14:0], 1'b0};
        end
        S_DATA: begin
          rd_sr <= {rd_sr[14:0], 1'b0};
          wr_sr <= wr_word;
        end
        default: ;
      endcase
    end
  end

  // Frame FSM, pad drive and write-back; outputs change one cycle after rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_PRE;
      pre_cnt   <= 6'd0;
      bit_cnt   <= 4'd0;
      op_msb    <= 1'b0;
      is_read   <= 1'b0;
      match     <= 1'b0;
      o_mdio    <= 1'b1;
      o_mdwe    <= 1'b0;
      o_wr_stb  <= 1'b0;
      o_wr_addr <= 5'd0;
      o_wr_data <= 16'd0;
      o_phy_rst <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? BMCR_RST : 16'h0000;
    end else begin
      o_wr_stb  <= 1'b0;
      o_phy_rst <= 1'b0;
      if (rise) begin
        pre_cnt <= bit_in ? pre_inc(pre_cnt) : 6'd0;
        case (state)
          S_PRE: begin
            if (!bit_in && pre_cnt >= PRE_MAX) state <= S_START;
          end
          S_START: begin
            bit_cnt <= 4'd0;
            if (bit_in) begin
              state <= S_OP;
            end else begin
              state   <= S_PRE;
              pre_cnt <= 6'd0;
            end
          end
          S_OP: begin
            if (bit_cnt == 4'd0) begin
              op_msb  <= bit_in;
              bit_cnt <= 4'd1;
            end else if (op_msb != bit_in) begin
              is_read <= op_msb;
              state   <= S_ADDR;
              bit_cnt <= 4'd0;
            end else begin
              state   <= S_PRE;
              pre_cnt <= 6'd0;
            end
          end
          S_ADDR: begin
            if (bit_cnt == 4'd9) begin
              match   <= (addr_sr[8:4] == PHYADDR);
              state   <= S_TA;
              bit_cnt <= 4'd0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
              if (drive) begin
                o_mdwe <= 1'b1;
                o_mdio <= 1'b0;
              end
            end else begin
              state   <= S_DATA;
              bit_cnt <= 4'd0;
              if (drive) o_mdio <= rd_sr[15];
            end
          end
          S_DATA: begin
            if (bit_cnt == 4'd15) begin
              state   <= S_PRE;
              pre_cnt <= 6'd0;
              o_mdwe  <= 1'b0;
              o_mdio  <= 1'b1;
              if (!is_read && match) begin
                o_wr_stb  <= 1'b1;
                o_wr_addr <= wr_ra;
                o_wr_data <= wr_word;
                o_phy_rst <= (wr_ra == 5'd0) && wr_word[15];
                if (wr_ra == 5'd0)
                  regs[0] <= bmcr_store(wr_word);
                else if (wr_ra >= 5'd4)
                  regs[wr_ra] <= wr_word;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              if (drive) o_mdio <= rd_sr[15];
            end
          end
          default: begin
            state   <= S_PRE;
            pre_cnt <= 6'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: a bit-banged MDIO master drives frames
// and compares read data, drive windows and write strobes to hand-derived values.
module tb_mdio_responder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_mdc = 1'b1;
  logic        m_out = 1'b1;
  logic        bus;
  logic [15:0] i_status = 16'hBEEF;
  logic        o_mdio, o_mdwe, o_wr_stb, o_phy_rst;
  logic [4:0]  o_wr_addr;
  logic [15:0] o_wr_data;

  int n_checks = 0;
  int n_errors = 0;
  int stb_cnt = 0;
  int prst_cnt = 0;

  assign bus = o_mdwe ? o_mdio : m_out;

  mdio_responder dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_mdc     (i_mdc),
    .i_mdio    (bus),
    .o_mdio    (o_mdio),
    .o_mdwe    (o_mdwe),
    .i_status  (i_status),
    .o_wr_stb  (o_wr_stb),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_phy_rst (o_phy_rst)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_wr_stb) stb_cnt++;
    if (o_phy_rst) prst_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic mdc_one();
    i_mdc = 1'b0;
    m_out = 1'b1;
    repeat (6) @(posedge i_clk);
    i_mdc = 1'b1;
    repeat (6) @(posedge i_clk);
  endtask

  // Sample bus just before each MDC rise, i.e. where the master samples.
  task automatic frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int abort_at,
                       output logic [15:0] rd, output logic ta0, output int drv);
    logic [31:0] body;
    logic        is_wr;
    is_wr = (op == 2'b01);
    body  = {2'b01, op, pa, ra, (is_wr ? 2'b10 : 2'b11), (is_wr ? wd : 16'hFFFF)};
    rd  = 16'h0000;
    ta0 = 1'b1;
    drv = 0;
    for (int i = 0; i < npre; i++) mdc_one();
    for (int i = 0; i < 32; i++) begin
      i_mdc = 1'b0;
      m_out = body[31-i];
      repeat (6) @(posedge i_clk);
      #1;
      if (i == abort_at) begin
        check_eq("mdwe_before_rst", {31'd0, o_mdwe}, 32'd1);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_async_mdwe", {31'd0, o_mdwe}, 32'd0);
        check_eq("rst_async_mdio", {31'd0, o_mdio}, 32'd1);
        check_eq("rst_wr_data", {16'd0, o_wr_data}, 32'd0);
        check_eq("rst_wr_addr", {27'd0, o_wr_addr}, 32'd0);
        check_eq("rst_wr_stb", {31'd0, o_wr_stb}, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        m_out = 1'b1;
        return;
      end
      if (o_mdwe) drv++;
      if (i == 15) ta0 = bus;
      if (i >= 16) rd[31-i] = bus;
      i_mdc = 1'b1;
      repeat (6) @(posedge i_clk);
    end
    m_out = 1'b1;
    #1;
  endtask

  task automatic do_read(input string tag, input logic [4:0] ra, input logic [15:0] exp);
    logic [15:0] rd;
    logic        ta0;
    int          drv;
    frame(32, 2'b10, 5'h01, ra, 16'h0000, -1, rd, ta0, drv);
    check_eq({tag, "_data"}, {16'd0, rd}, {16'd0, exp});
    check_eq({tag, "_drv"}, drv, 32'd17);
  endtask

  task automatic do_write(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
    logic [15:0] rd;
    logic        ta0;
    int          drv;
    frame(32, 2'b01, pa, ra, wd, -1, rd, ta0, drv);
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("wr_frame_no_drive", drv, 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    logic        ta0;
    int          drv;
    int          s0, p0;

    repeat (4) @(posedge i_clk);
    #1;
    check_eq("rst_mdio", {31'd0, o_mdio}, 32'd1);
    check_eq("rst_mdwe", {31'd0, o_mdwe}, 32'd0);
    check_eq("rst_stb", {31'd0, o_wr_stb}, 32'd0);
    check_eq("rst_addr", {27'd0, o_wr_addr}, 32'd0);
    check_eq("rst_data", {16'd0, o_wr_data}, 32'd0);
    check_eq("rst_phy_rst", {31'd0, o_phy_rst}, 32'd0);
    i_rst_n = 1'b1;
    repeat (4) @(posedge i_clk);

    // Read PHY ID 1 with explicit TA and release checks.
    frame(32, 2'b10, 5'h01, 5'd2, 16'h0000, -1, rd, ta0, drv);
    check_eq("id1_data", {16'd0, rd}, 32'h2000);
    check_eq("id1_ta0", {31'd0, ta0}, 32'd0);
    check_eq("id1_drv", drv, 32'd17);
    check_eq("id1_rel_mdwe", {31'd0, o_mdwe}, 32'd0);
    check_eq("id1_rel_mdio", {31'd0, o_mdio}, 32'd1);

    do_read("bmcr_rst", 5'd0, 16'h3100);
    do_read("status", 5'd1, 16'hBEEF);
    do_read("id2", 5'd3, 16'h5C90);

    s0 = stb_cnt;
    do_write(5'h01, 5'd4, 16'hA5C3);
    check_eq("w4_stb", stb_cnt - s0, 32'd1);
    check_eq("w4_addr", {27'd0, o_wr_addr}, 32'd4);
    check_eq("w4_data", {16'd0, o_wr_data}, 32'hA5C3);
    do_read("r4", 5'd4, 16'hA5C3);

    s0 = stb_cnt;
    p0 = prst_cnt;
    do_write(5'h01, 5'd0, 16'h9200);
    check_eq("w0_phy_rst", prst_cnt - p0, 32'd1);
    check_eq("w0_stb", stb_cnt - s0, 32'd1);
    check_eq("w0_data", {16'd0, o_wr_data}, 32'h9200);
    do_read("r0_selfclr", 5'd0, 16'h1200);

    s0 = stb_cnt;
    p0 = prst_cnt;
    do_write(5'h01, 5'd2, 16'h1234);
    check_eq("w2_stb", stb_cnt - s0, 32'd1);
    check_eq("w2_no_phy_rst", prst_cnt - p0, 32'd0);
    do_read("r2_ro", 5'd2, 16'h2000);

    frame(32, 2'b10, 5'h02, 5'd4, 16'h0000, -1, rd, ta0, drv);
    check_eq("badpa_rd_drv", drv, 32'd0);
    s0 = stb_cnt;
    do_write(5'h02, 5'd5, 16'hFFFF);
    check_eq("badpa_wr_stb", stb_cnt - s0, 32'd0);
    check_eq("badpa_wr_addr_hold", {27'd0, o_wr_addr}, 32'd2);
    do_read("r5_untouched", 5'd5, 16'h0000);

    s0 = stb_cnt;
    frame(32, 2'b11, 5'h01, 5'd4, 16'h0000, -1, rd, ta0, drv);
    check_eq("op11_drv", drv, 32'd0);
    check_eq("op11_stb", stb_cnt - s0, 32'd0);
    do_read("after_op11", 5'd4, 16'hA5C3);

    s0 = stb_cnt;
    frame(31, 2'b01, 5'h01, 5'd6, 16'h1110, -1, rd, ta0, drv);
    repeat (2) @(posedge i_clk);
    check_eq("short_wr_stb", stb_cnt - s0, 32'd0);
    frame(31, 2'b10, 5'h01, 5'd2, 16'h0000, -1, rd, ta0, drv);
    check_eq("short_rd_drv", drv, 32'd0);
    do_read("r6_untouched", 5'd6, 16'h0000);

    // Abort a read during DATA bit 7 with an asynchronous reset.
    frame(32, 2'b10, 5'h01, 5'd4, 16'h0000, 23, rd, ta0, drv);
    do_read("post_rst_r4", 5'd4, 16'h0000);
    do_read("post_rst_r0", 5'd0, 16'h3100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
